// File: rtl/y86_pkg.sv
// Shared Y86-64 status codes and the SEQ sequencer state type.
package y86_pkg;

  // Architectural status register values (one-hot).
  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0010;
  localparam logic [3:0] STAT_ADR = 4'b0001;
  localparam logic [3:0] STAT_INS = 4'b0100;

  // Sequencer states: six stage states plus idle, pause and stop.
  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StPcUpd,
    StPause,
    StStop
  } seq_state_e;

  // True in the states that step a stage of the datapath.
  function automatic logic is_stage(input seq_state_e s);
    return s inside {StFetch, StDecode, StExecute, StMemory, StWriteback, StPcUpd};
  endfunction

endpackage

// File: rtl/seq_run_ctrl.sv
// Y86-64 SEQ sequencer: owns PC and status, strobes one stage per cycle, stops on HLT/ADR/INS.
module seq_run_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 64,
  parameter int unsigned        CNT_W     = 32,
  parameter logic [ADDR_W-1:0]  START_PC  = '0,
  parameter int unsigned        MAX_INSTR = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              step_mode_i,
  input  logic              step_i,
  input  logic              f_in_error_i,
  input  logic              f_bad_mem_i,
  input  logic              f_halt_i,
  input  logic              m_bad_mem_i,
  input  logic [ADDR_W-1:0] pc_next_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              en_fetch_o,
  output logic              en_decode_o,
  output logic              en_execute_o,
  output logic              en_memory_o,
  output logic              en_writeback_o,
  output logic              en_pc_o,
  output logic [3:0]        stat_o,
  output logic              running_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  instr_cnt_o
);

  localparam logic [CNT_W-1:0] MaxInstrCnt = CNT_W'(MAX_INSTR);
  localparam logic             LimitOn     = (MAX_INSTR != 0);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]  instr_inc;
  logic              fetch_err;
  logic              limit_hit;

  assign instr_inc = instr_q + CNT_W'(1);
  assign fetch_err = f_bad_mem_i | f_in_error_i | f_halt_i;
  assign limit_hit = LimitOn && (instr_inc == MaxInstrCnt);

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start_i) state_d = StFetch;
      StFetch:     state_d = fetch_err ? StStop : StDecode;
      StDecode:    state_d = StExecute;
      StExecute:   state_d = StMemory;
      StMemory:    state_d = m_bad_mem_i ? StStop : StWriteback;
      StWriteback: state_d = StPcUpd;
      StPcUpd: begin
        if (limit_hit)        state_d = StStop;
        else if (step_mode_i) state_d = StPause;
        else                  state_d = StFetch;
      end
      // Dropping step_mode while paused resumes free-running execution.
      StPause:     if (step_i || !step_mode_i) state_d = StFetch;
      StStop:      state_d = StStop;
      default:     state_d = StIdle;
    endcase
  end

  // Architectural PC, status and counters; next values.
  always_comb begin
    pc_d    = pc_q;
    stat_d  = stat_q;
    instr_d = instr_q;
    cycle_d = is_stage(state_q) ? cycle_q + CNT_W'(1) : cycle_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pc_d    = START_PC;
          stat_d  = STAT_AOK;
          cycle_d = '0;
          instr_d = '0;
        end
      end
      StFetch: begin
        // Address fault outranks illegal instruction, which outranks halt.
        if (f_bad_mem_i)       stat_d = STAT_ADR;
        else if (f_in_error_i) stat_d = STAT_INS;
        else if (f_halt_i)     stat_d = STAT_HLT;
      end
      StMemory: begin
        if (m_bad_mem_i) stat_d = STAT_ADR;
      end
      StPcUpd: begin
        pc_d    = pc_next_i;
        instr_d = instr_inc;
        if (limit_hit) stat_d = STAT_HLT;
      end
      default: ;
    endcase
  end

  // Architectural register update.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q    <= START_PC;
      stat_q  <= STAT_AOK;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  // Stage strobes decoded from state; masked by reset so an aborted stage never fires.
  always_comb begin
    en_fetch_o     = 1'b0;
    en_decode_o    = 1'b0;
    en_execute_o   = 1'b0;
    en_memory_o    = 1'b0;
    en_writeback_o = 1'b0;
    en_pc_o        = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        StFetch:     en_fetch_o     = 1'b1;
        StDecode:    en_decode_o    = 1'b1;
        StExecute:   en_execute_o   = 1'b1;
        StMemory:    en_memory_o    = 1'b1;
        StWriteback: en_writeback_o = 1'b1;
        StPcUpd:     en_pc_o        = 1'b1;
        default: ;
      endcase
    end
    running_o = is_stage(state_q) || (state_q == StPause);
    done_o    = (state_q == StStop);
  end

  assign pc_o        = pc_q;
  assign stat_o      = stat_q;
  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Scoreboard bench for seq_run_ctrl: random programs run against a per-instruction cost model.
module tb_seq_run_ctrl;

  localparam int unsigned AW = 64;
  localparam int unsigned CW = 32;
  localparam logic [3:0]  SAok = 4'b1000;
  localparam logic [3:0]  SHlt = 4'b0010;
  localparam logic [3:0]  SAdr = 4'b0001;
  localparam logic [3:0]  SIns = 4'b0100;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] nxt;
    bit          halt;
    bit          ins;
    bit          adr_f;
    bit          adr_m;
  } instr_t;

  typedef struct {
    bit          fin;
    logic [3:0]  stat;
    logic [63:0] pc;
    logic [31:0] icnt;
    logic [31:0] ccnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, step_mode, step;
  logic          f_in_error, f_bad_mem, f_halt, m_bad_mem;
  logic [AW-1:0] pc_next, pc;
  logic          en_f, en_d, en_e, en_m, en_w, en_p;
  logic [3:0]    stat;
  logic          running, done;
  logic [CW-1:0] cyc_cnt, ins_cnt;

  logic          start1, zero1;
  logic [AW-1:0] pc_next1, pc1;
  logic          en1_f, en1_d, en1_e, en1_m, en1_w, en1_p;
  logic [3:0]    stat1;
  logic          running1, done1;
  logic [CW-1:0] cyc1, ins1;

  seq_run_ctrl #(.ADDR_W(AW), .CNT_W(CW), .START_PC(64'd0), .MAX_INSTR(0)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .step_mode_i(step_mode), .step_i(step),
    .f_in_error_i(f_in_error), .f_bad_mem_i(f_bad_mem), .f_halt_i(f_halt),
    .m_bad_mem_i(m_bad_mem), .pc_next_i(pc_next), .pc_o(pc),
    .en_fetch_o(en_f), .en_decode_o(en_d), .en_execute_o(en_e), .en_memory_o(en_m),
    .en_writeback_o(en_w), .en_pc_o(en_p), .stat_o(stat), .running_o(running),
    .done_o(done), .cycle_cnt_o(cyc_cnt), .instr_cnt_o(ins_cnt)
  );

  // Second instance exercises the retire limit on a jmp-to-self loop at address 0.
  seq_run_ctrl #(.ADDR_W(AW), .CNT_W(CW), .START_PC(64'd0), .MAX_INSTR(4)) dut_lim (
    .clock_i(clk), .reset_i(rst), .start_i(start1), .step_mode_i(zero1), .step_i(zero1),
    .f_in_error_i(zero1), .f_bad_mem_i(zero1), .f_halt_i(zero1),
    .m_bad_mem_i(zero1), .pc_next_i(pc_next1), .pc_o(pc1),
    .en_fetch_o(en1_f), .en_decode_o(en1_d), .en_execute_o(en1_e), .en_memory_o(en1_m),
    .en_writeback_o(en1_w), .en_pc_o(en1_p), .stat_o(stat1), .running_o(running1),
    .done_o(done1), .cycle_cnt_o(cyc1), .instr_cnt_o(ins1)
  );

  instr_t      prog[16];
  int          prog_n;
  logic [63:0] cur_addr;
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  bit          mon_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int find_idx(input logic [63:0] a);
    for (int i = 0; i < prog_n; i++) if (prog[i].addr == a) return i;
    return -1;
  endfunction

  task automatic add_instr(input int len, input bit h, input bit ins, input bit af, input bit am);
    prog[prog_n].addr  = cur_addr;
    prog[prog_n].nxt   = cur_addr + 64'(len);
    prog[prog_n].halt  = h;
    prog[prog_n].ins   = ins;
    prog[prog_n].adr_f = af;
    prog[prog_n].adr_m = am;
    cur_addr = cur_addr + 64'(len);
    prog_n++;
  endtask

  task automatic clear_prog();
    prog_n   = 0;
    cur_addr = 64'd0;
  endtask

  task automatic push_exp(input bit fin, input logic [3:0] s, input logic [63:0] p,
                          input int k, input int c);
    exp_t e;
    e.fin = fin; e.stat = s; e.pc = p; e.icnt = 32'(k); e.ccnt = 32'(c);
    sb_q.push_back(e);
  endtask

  // Reference: an instruction costs 1 cycle to fetch-fault, 4 to memory-fault, 6 to retire.
  task automatic model_run();
    logic [63:0] p = 64'd0;
    int k = 0;
    int c = 0;
    int i;
    bit stop = 1'b0;
    for (int n = 0; n < 64 && !stop; n++) begin
      i = find_idx(p);
      c += 1;
      stop = 1'b1;
      if (i < 0 || prog[i].adr_f) push_exp(1'b1, SAdr, p, k, c);
      else if (prog[i].ins)        push_exp(1'b1, SIns, p, k, c);
      else if (prog[i].halt)       push_exp(1'b1, SHlt, p, k, c);
      else begin
        c += 3;
        if (prog[i].adr_m) push_exp(1'b1, SAdr, p, k, c);
        else begin
          c += 2;
          p = prog[i].nxt;
          k += 1;
          push_exp(1'b0, SAok, p, k, c);
          stop = 1'b0;
        end
      end
    end
  endtask

  // Environment: stands in for the stage modules, answering for the instruction at pc.
  initial begin
    zero1 = 1'b0;
    pc_next1 = 64'd0;
    forever begin
      int i;
      i = find_idx(pc);
      if (i < 0) begin
        f_bad_mem = 1'b1; f_in_error = 1'b0; f_halt = 1'b0; m_bad_mem = 1'b0; pc_next = pc;
      end else begin
        f_bad_mem  = prog[i].adr_f;
        f_in_error = prog[i].ins;
        f_halt     = prog[i].halt;
        m_bad_mem  = prog[i].adr_m;
        pc_next    = prog[i].nxt;
      end
      @(negedge clk);
    end
  end

  // Monitor: retire events and stop events are compared against the scoreboard queue.
  initial begin
    bit prev_p = 1'b0;
    bit prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      chk("strobe_onehot", 64'($countones({en_f, en_d, en_e, en_m, en_w, en_p}) > 1), 64'd0);
      chk("strobe_onehot_lim",
          64'($countones({en1_f, en1_d, en1_e, en1_m, en1_w, en1_p}) > 1), 64'd0);
      if (mon_en && (prev_p || (done && !prev_done))) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: got unexpected event, required none (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk(prev_p ? "retire_pc" : "stop_pc", pc, e.pc);
          chk(prev_p ? "retire_stat" : "stop_stat", 64'(stat), 64'(e.stat));
          chk(prev_p ? "retire_icnt" : "stop_icnt", 64'(ins_cnt), 64'(e.icnt));
          chk(prev_p ? "retire_ccnt" : "stop_ccnt", 64'(cyc_cnt), 64'(e.ccnt));
          chk("event_kind_done", 64'(done), 64'(e.fin));
          if (e.fin) begin
            chk("stop_strobes", 64'({en_f, en_d, en_e, en_m, en_w, en_p}), 64'd0);
            chk("stop_running", 64'(running), 64'd0);
          end
        end
      end
      prev_p    = en_p;
      prev_done = done;
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; step = 1'b0; step_mode = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // rnd: random stray start/step pulses and occasional step_mode drop, none of which
  // may change the outcome.
  task automatic run_prog(input string nm, input bit stepm, input bit rnd);
    bit fin = 1'b0;
    do_reset();
    step_mode = stepm;
    model_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 2000 && !fin; t++) begin
      @(negedge clk);
      if (done) fin = 1'b1;
      else if (running && !(en_f | en_d | en_e | en_m | en_w | en_p)) begin
        step = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rnd && $urandom_range(0, 7) == 0) step_mode = 1'b0;
      end else begin
        step  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        start = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
      end
    end
    step = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_finished"}, 64'(fin), 64'd1);
    chk({nm, "_stop_held"}, 64'(done), 64'd1);
    chk({nm, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; step = 1'b0; step_mode = 1'b0;
    clear_prog();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 64'd0);
    chk("rst_stat", 64'(stat), 64'(SAok));
    chk("rst_run_done", 64'({running, done}), 64'd0);
    chk("rst_counts", 64'({cyc_cnt, ins_cnt}), 64'd0);
    chk("rst_strobes", 64'({en_f, en_d, en_e, en_m, en_w, en_p}), 64'd0);

    // irmovq; addq; halt
    clear_prog();
    add_instr(10, 0, 0, 0, 0); add_instr(2, 0, 0, 0, 0); add_instr(1, 1, 0, 0, 0);
    run_prog("halt3", 1'b0, 1'b0);

    // Illegal instruction at the second fetch.
    clear_prog();
    add_instr(10, 0, 0, 0, 0); add_instr(2, 0, 1, 0, 0);
    run_prog("ins2", 1'b0, 1'b0);

    // mrmovq faulting in memory.
    clear_prog();
    add_instr(10, 0, 0, 0, 1);
    run_prog("memfault", 1'b0, 1'b0);

    // Fetch-fault priority: all three flags at once must report ADR.
    clear_prog();
    add_instr(3, 0, 0, 0, 0); add_instr(1, 1, 1, 1, 0);
    run_prog("prio", 1'b0, 1'b0);

    // Single-step three instructions, then halt.
    clear_prog();
    add_instr(10, 0, 0, 0, 0); add_instr(2, 0, 0, 0, 0); add_instr(10, 0, 0, 0, 0);
    add_instr(1, 1, 0, 0, 0);
    run_prog("step3", 1'b1, 1'b0);

    // Reset in the E stage of the second instruction.
    begin
      int ne = 0;
      clear_prog();
      add_instr(10, 0, 0, 0, 0); add_instr(2, 0, 0, 0, 0); add_instr(1, 1, 0, 0, 0);
      do_reset();
      mon_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 100 && ne < 2; t++) begin
        @(negedge clk);
        if (en_e) ne++;
      end
      chk("rstE_reached", 64'(ne), 64'd2);
      rst = 1'b1;
      #1;
      chk("rstE_no_strobe", 64'({en_f, en_d, en_e, en_m, en_w, en_p}), 64'd0);
      @(negedge clk);
      chk("rstE_pc", pc, 64'd0);
      chk("rstE_stat", 64'(stat), 64'(SAok));
      chk("rstE_idle", 64'({running, done}), 64'd0);
      chk("rstE_counts", 64'({cyc_cnt, ins_cnt}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rstE_strobes", 64'({en_f, en_d, en_e, en_m, en_w, en_p}), 64'd0);
      mon_en = 1'b1;
    end

    // Retire limit of 4 on an infinite jmp loop.
    begin
      bit fin1 = 1'b0;
      do_reset();
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int t = 0; t < 200 && !fin1; t++) begin
        @(negedge clk);
        if (done1) fin1 = 1'b1;
      end
      chk("lim_done", 64'(fin1), 64'd1);
      chk("lim_stat", 64'(stat1), 64'(SHlt));
      chk("lim_icnt", 64'(ins1), 64'd4);
      chk("lim_ccnt", 64'(cyc1), 64'd24);
      chk("lim_pc", pc1, 64'd0);
    end

    // Random programs.
    for (int r = 0; r < 30; r++) begin
      int n;
      clear_prog();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        int len;
        len = $urandom_range(1, 10);
        case ($urandom_range(0, 11))
          0:       add_instr(len, 1'($urandom_range(0, 1)), 1, 0, 0);
          1:       add_instr(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
          2:       add_instr(len, 0, 0, 0, 1);
          3:       add_instr(len, 1, 0, 0, 0);
          default: add_instr(len, 0, 0, 0, 0);
        endcase
      end
      // Without a trailing halt the PC runs off the image and must fault on fetch.
      if ($urandom_range(0, 3) != 0) add_instr(1, 1, 0, 0, 0);
      run_prog("rand", 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
